board_scanner: RTL and testbench
================================

Name: board_scanner

Overview:
- Upstream feeder of the per-pixel block shader.
- Converts the raster position from the VGA timing generator into:
  - playfield cell coordinates;
  - the pixel offset inside the cell (block_x/block_y);
  - the cell's 12-bit colour, fetched from the board RAM and palette.
- Outputs are registered and aligned with delayed sync/DE, so the shader and the VGA output stage consume them directly.

Parameters:
- COLS, 10, playfield width in cells
- ROWS, 15, playfield height in cells
- CELL_W, 26, cell width in pixels (block_x range 0..CELL_W-1)
- CELL_H, 32, cell height in pixels (block_y range 0..CELL_H-1)
- FIELD_X0, 190, first pixel column of the playfield
- FIELD_Y0, 0, first pixel row of the playfield
- ADDR_W, 8, board RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- de_in  in  1  active-video enable
- hs_in  in  1  hsync
- vs_in  in  1  vsync
- px  in  10  current pixel column
- py  in  10  current pixel row
- cell_addr  out  ADDR_W  board RAM read address, row*COLS+col
- cell_rd_data  in  3  board RAM data, valid 1 cycle after cell_addr; 0 = empty, 1..7 = piece id
- block_x  out  6  pixel offset inside cell
- block_y  out  6  line offset inside cell
- cell_color  out  12  RGB444 colour of the cell
- cell_on  out  1  pixel is inside the field and the cell is drawn
- de_out  out  1  de_in delayed by 3
- hs_out  out  1  hs_in delayed by 3
- vs_out  out  1  vs_in delayed by 3

Behaviour:
- Reset: every output and internal register is 0. The counters stay idle until the next FIELD_Y0 line start.
- Pipeline, fixed latency 3 cycles from (px, py, de_in) at cycle T to outputs at T+3. No stalls, no backpressure.
  - Stage 1 (T+1): update counters; register in_field and cell_addr.
  - Stage 2 (T+2): RAM returns data; delay block_x/block_y/in_field one more cycle.
  - Stage 3 (T+3): palette lookup, registered to outputs.
- Horizontal counters (bx, col):
  - When de_in and px==FIELD_X0: bx=0, col=0.
  - Else, while x-in-field: bx++; when bx==CELL_W-1, bx=0 and col++.
  - x-in-field holds from px==FIELD_X0 through px==FIELD_X0+COLS*CELL_W-1.
- Vertical counters (by, row), updated only on line start (de_in and px==FIELD_X0):
  - py==FIELD_Y0: by=0, row=0, y_active=1.
  - Else if y_active: by++, wrapping at CELL_H-1 with row++.
  - When row would reach ROWS: y_active=0.
- in_field = x-in-field & y_active & de_in.
- Outside the field: cell_addr holds its last value, block_x/block_y = 0, cell_on = 0, cell_color = 0.
- Wrap checks: col never exceeds COLS-1 and row never exceeds ROWS-1. Counter overflow is impossible by construction; this is asserted in simulation.
- Palette, 3-bit id → 12 bit:
  - 0 → 000
  - 1 → 0FF
  - 2 → 00F
  - 3 → F80
  - 4 → FF0
  - 5 → 0F0
  - 6 → F0F
  - 7 → F00
- cell_on = in_field & (id != 0), in the same cycle as cell_color.
- vs_in asserted mid-frame: no effect on the counters. Only the FIELD_Y0 line start re-primes them.
- Reset mid-line: outputs read 0 on the next cycle. Rendering resumes at the next frame's FIELD_Y0 line.

Optional Feature:
- Macro: BOARD_SCANNER_GRID_EN.
- Defined: an empty cell inside the field gives cell_on=1 and cell_color=12'h222, so the shader draws a faint grid.
- Undefined: an empty cell gives cell_on=0 and cell_color=0.

Decomposition:
- Shared package tetris_pkg holds:
  - palette constants PAL_0..PAL_7 and GRID_COLOR;
  - piece-id width;
  - default cell geometry CELL_W/CELL_H, which the shader also uses.
- One natural sub-module: scan_delay, a parameterised-width, parameterised-depth shift register used for the sync/DE and block_x/block_y alignment.

Test Plan:
- Reset held 5 cycles with an active raster → all outputs 0. Release at frame start → first valid output exactly 3 cycles after the px=190, py=0 input.
- Line py=0, RAM filled with id=1 → at px=190+26*k: block_x=0 and cell_addr=k for k=0..9. At px=215: block_x=25. At px=450: cell_on=0.
- Rows: py=31 gives block_y=31, row 0. py=32 gives block_y=0, cell_addr=10 at px=190. py=480 and beyond gives cell_on=0 (y_active cleared after row 14).
- RAM address 23 = id 4 → at px=190+3*26+5, py=2*32+7: outputs block_x=5, block_y=7, cell_color=FF0, cell_on=1.
- de_in/hs_in/vs_in random pattern → de_out/hs_out/vs_out equal the inputs delayed exactly 3 cycles.
- Empty cell (id 0): with GRID_EN defined → cell_on=1, cell_color=222. Undefined → cell_on=0, cell_color=000.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield definitions: piece-id width, default cell geometry and the RGB444 palette.
// The grid colour is used only when BOARD_SCANNER_GRID_EN is defined.
package tetris_pkg;

  localparam int PIECE_W        = 3;
  localparam int DEFAULT_CELL_W = 26;
  localparam int DEFAULT_CELL_H = 32;

  localparam logic [11:0] PAL_0      = 12'h000;
  localparam logic [11:0] PAL_1      = 12'h0FF;
  localparam logic [11:0] PAL_2      = 12'h00F;
  localparam logic [11:0] PAL_3      = 12'hF80;
  localparam logic [11:0] PAL_4      = 12'hFF0;
  localparam logic [11:0] PAL_5      = 12'h0F0;
  localparam logic [11:0] PAL_6      = 12'hF0F;
  localparam logic [11:0] PAL_7      = 12'hF00;
  localparam logic [11:0] GRID_COLOR = 12'h222;

  function automatic logic [11:0] piece_color(input logic [PIECE_W-1:0] id);
    logic [11:0] c;
    case (id)
      3'd0:    c = PAL_0;
      3'd1:    c = PAL_1;
      3'd2:    c = PAL_2;
      3'd3:    c = PAL_3;
      3'd4:    c = PAL_4;
      3'd5:    c = PAL_5;
      3'd6:    c = PAL_6;
      3'd7:    c = PAL_7;
      default: c = PAL_0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scan_delay.sv
// Fixed-depth shift register with synchronous reset, used to keep sync/DE and
// cell offsets aligned with the board RAM and palette pipeline.
module scan_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) q_reg <= '0;
          else     q_reg <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) q_reg <= '0;
          else     q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/board_scanner.sv
// Raster-to-playfield scanner: cell counters, board RAM address, palette lookup, 3-cycle aligned outputs.
// Define BOARD_SCANNER_GRID_EN to draw empty in-field cells in the faint grid colour.
module board_scanner
  import tetris_pkg::*;
#(
  parameter int COLS     = 10,
  parameter int ROWS     = 15,
  parameter int CELL_W   = DEFAULT_CELL_W,
  parameter int CELL_H   = DEFAULT_CELL_H,
  parameter int FIELD_X0 = 190,
  parameter int FIELD_Y0 = 0,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic [2:0]        cell_rd_data,
  output logic [5:0]        block_x,
  output logic [5:0]        block_y,
  output logic [11:0]       cell_color,
  output logic              cell_on,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out
);

  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);

  localparam logic [9:0]       X_FIRST  = 10'(FIELD_X0);
  localparam logic [9:0]       X_LAST   = 10'(FIELD_X0 + COLS * CELL_W - 1);
  localparam logic [9:0]       Y_FIRST  = 10'(FIELD_Y0);
  localparam logic [5:0]       BX_LAST  = 6'(CELL_W - 1);
  localparam logic [5:0]       BY_LAST  = 6'(CELL_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  // Stage 1: raster counters
  logic [5:0]        bx_reg, bx_next, by_reg, by_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic              y_active_reg, y_active_next;
  logic              in_field_reg, in_field_next;
  logic [ADDR_W-1:0] cell_addr_reg, cell_addr_next;
  logic              line_start, x_in_field;

  always_comb begin
    bx_next        = bx_reg;
    col_next       = col_reg;
    by_next        = by_reg;
    row_next       = row_reg;
    y_active_next  = y_active_reg;
    cell_addr_next = cell_addr_reg;
    line_start     = de_in && (px == X_FIRST);
    x_in_field     = (px >= X_FIRST) && (px <= X_LAST);

    if (line_start) begin
      bx_next  = '0;
      col_next = '0;
      if (py == Y_FIRST) begin
        by_next       = '0;
        row_next      = '0;
        y_active_next = 1'b1;
      end else if (y_active_reg) begin
        if (by_reg == BY_LAST) begin
          by_next = '0;
          if (row_reg == ROW_LAST) y_active_next = 1'b0;
          else                     row_next      = row_reg + 1'b1;
        end else begin
          by_next = by_reg + 1'b1;
        end
      end
    end else if (x_in_field && de_in) begin
      // Gated by DE so blanking lines sweeping the field columns cannot run col past the edge.
      if (bx_reg == BX_LAST) begin
        bx_next  = '0;
        col_next = col_reg + 1'b1;
      end else begin
        bx_next = bx_reg + 1'b1;
      end
    end

    in_field_next = x_in_field && y_active_next && de_in;
    if (in_field_next) begin
      cell_addr_next = ADDR_W'(int'(row_next) * COLS + int'(col_next));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bx_reg        <= '0;
      by_reg        <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      y_active_reg  <= 1'b0;
      in_field_reg  <= 1'b0;
      cell_addr_reg <= '0;
    end else begin
      bx_reg        <= bx_next;
      by_reg        <= by_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      y_active_reg  <= y_active_next;
      in_field_reg  <= in_field_next;
      cell_addr_reg <= cell_addr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (col_next <= COL_LAST);
      assert (row_next <= ROW_LAST);
    end
  end

  assign cell_addr = cell_addr_reg;

  // Stage 2: wait for the board RAM read while carrying the offsets along
  logic [12:0] pix_d;
  logic        in_field_d;
  logic [5:0]  bx_d, by_d;

  scan_delay #(.WIDTH(13), .DEPTH(1)) u_pix_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({in_field_reg, by_reg, bx_reg}),
    .dout (pix_d)
  );

  assign in_field_d = pix_d[12];
  assign by_d       = pix_d[11:6];
  assign bx_d       = pix_d[5:0];

  scan_delay #(.WIDTH(3), .DEPTH(3)) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({de_in, hs_in, vs_in}),
    .dout ({de_out, hs_out, vs_out})
  );

  // Stage 3: palette lookup into the output registers
  logic        on_next;
  logic [11:0] color_next;
  logic [5:0]  block_x_reg, block_y_reg;
  logic [11:0] cell_color_reg;
  logic        cell_on_reg;

  always_comb begin
    on_next    = 1'b0;
    color_next = '0;
    if (in_field_d) begin
      if (cell_rd_data != '0) begin
        on_next    = 1'b1;
        color_next = piece_color(cell_rd_data);
      end
`ifdef BOARD_SCANNER_GRID_EN
      else begin
        on_next    = 1'b1;
        color_next = GRID_COLOR;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block_x_reg    <= '0;
      block_y_reg    <= '0;
      cell_color_reg <= '0;
      cell_on_reg    <= 1'b0;
    end else begin
      block_x_reg    <= in_field_d ? bx_d : 6'd0;
      block_y_reg    <= in_field_d ? by_d : 6'd0;
      cell_color_reg <= color_next;
      cell_on_reg    <= on_next;
    end
  end

  assign block_x    = block_x_reg;
  assign block_y    = block_y_reg;
  assign cell_color = cell_color_reg;
  assign cell_on    = cell_on_reg;

endmodule

// File: tb/tb_board_scanner.sv
// Scoreboard bench for board_scanner: stimulus pushes expected pixels, a negedge monitor pops and compares.
// Honours BOARD_SCANNER_GRID_EN for the empty-cell expectation.
module tb_board_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [9:0] px = '0, py = '0;
  logic [7:0] cell_addr;
  logic [2:0] cell_rd_data;
  logic [5:0] block_x, block_y;
  logic [11:0] cell_color;
  logic       cell_on, de_out, hs_out, vs_out;

  always #5 clk = ~clk;

  board_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .de_in        (de_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .px           (px),
    .py           (py),
    .cell_addr    (cell_addr),
    .cell_rd_data (cell_rd_data),
    .block_x      (block_x),
    .block_y      (block_y),
    .cell_color   (cell_color),
    .cell_on      (cell_on),
    .de_out       (de_out),
    .hs_out       (hs_out),
    .vs_out       (vs_out)
  );

  // Board RAM model with one-cycle registered read
  logic [2:0] ram [256];
  always @(posedge clk) cell_rd_data <= ram[cell_addr];

  localparam logic [11:0] PAL [8] = '{12'h000, 12'h0FF, 12'h00F, 12'hF80,
                                      12'hFF0, 12'h0F0, 12'hF0F, 12'hF00};

  typedef struct {
    int          issue;
    logic        de, hs, vs, infield, on, show;
    logic [5:0]  bx, by;
    logic [7:0]  addr;
    logic [11:0] color;
    int          x, y;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One stimulus cycle; the expected response comes from direct px/py arithmetic.
  task automatic drive(input int x, input int y, input logic d, input bit show,
                       input bit do_push, input logic r);
    exp_t e;
    int   dx;
    logic [2:0] id;
    @(posedge clk);
    #1;
    rst   = r;
    px    = 10'(x);
    py    = 10'(y);
    de_in = d;
    hs_in = 1'($urandom_range(0, 1));
    vs_in = 1'($urandom_range(0, 1));
    if (r) begin
      started = 0;
      while (q.size() > 0 && q[$].issue >= cyc - 2) void'(q.pop_back());
      return;
    end
    if (d && x == 190 && y == 0) started = 1;
    dx = x - 190;
    e.issue   = cyc;
    e.de      = d;
    e.hs      = hs_in;
    e.vs      = vs_in;
    e.show    = show;
    e.x       = x;
    e.y       = y;
    e.infield = d && started && dx >= 0 && dx < 260 && y < 480;
    e.bx      = e.infield ? 6'(dx % 26) : 6'd0;
    e.by      = e.infield ? 6'(y % 32) : 6'd0;
    e.addr    = e.infield ? 8'((y / 32) * 10 + dx / 26) : 8'd0;
    id        = ram[e.addr];
`ifdef BOARD_SCANNER_GRID_EN
    e.on      = e.infield;
    e.color   = !e.infield ? 12'h000 : (id == 3'd0) ? 12'h222 : PAL[id];
`else
    e.on      = e.infield && id != 3'd0;
    e.color   = e.on ? PAL[id] : 12'h000;
`endif
    if (do_push) q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_cell_addr"}, cell_addr, 0);
    chk({tag, "_block_x"}, block_x, 0);
    chk({tag, "_block_y"}, block_y, 0);
    chk({tag, "_cell_color"}, cell_color, 0);
    chk({tag, "_cell_on"}, cell_on, 0);
    chk({tag, "_sync"}, {de_out, hs_out, vs_out}, 0);
  endtask

  function automatic bit is_tagged(input int x, input int y);
    if (y == 0 && x >= 190 && x <= 450 && ((x - 190) % 26 == 0 || x == 215 || x == 450)) return 1;
    if ((y == 31 || y == 32 || y == 480) && x == 190) return 1;
    if (y == 71 && (x == 273 || x == 294)) return 1;
    if (y == 479 && x == 449) return 1;
    return 0;
  endfunction

  // Monitor: cell_addr is presented two cycles before the pixel outputs.
  logic [7:0] addr_h1, addr_h2;
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].issue + 3 == cyc) begin
      e = q.pop_front();
      chk("de_out", de_out, e.de);
      chk("hs_out", hs_out, e.hs);
      chk("vs_out", vs_out, e.vs);
      chk("block_x", block_x, e.bx);
      chk("block_y", block_y, e.by);
      chk("cell_on", cell_on, e.on);
      chk("cell_color", cell_color, e.color);
      if (e.infield) chk("cell_addr", addr_h2, e.addr);
      if (e.show)
        $display("txn px=%0d py=%0d: block_x=%0d block_y=%0d cell_addr=%0d cell_on=%0b cell_color=%03h (exp %0d %0d %0d %0b %03h)",
                 e.x, e.y, block_x, block_y, addr_h2, cell_on, cell_color,
                 e.bx, e.by, e.addr, e.on, e.color);
    end else if (!rst) begin
      chk("idle_de_out", de_out, 0);
    end
    addr_h2 = addr_h1;
    addr_h1 = cell_addr;
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 3'd1;
    ram[3]   = 3'd3;
    ram[10]  = 3'd2;
    ram[23]  = 3'd4;
    ram[24]  = 3'd0;
    ram[149] = 3'd7;

    // Reset held with an active raster
    for (int i = 0; i < 5; i++) begin
      drive(100 + i, 0, 1'b1, 0, 0, 1'b1);
      check_zero("reset");
    end

    // Frame: full lines at the interesting rows, short lines elsewhere to keep counters primed
    for (int y = 0; y < 482; y++) begin
      int last;
      last = (y inside {0, 31, 32, 71, 479, 480}) ? 455 : 192;
      for (int x = 190; x <= last; x++) drive(x, y, 1'b1, is_tagged(x, y), 1, 1'b0);
      drive(0, y, 1'b0, 0, 1, 1'b0);
    end

    // Reset in the middle of a field line, then resume on the next FIELD_Y0 line
    for (int x = 190; x < 200; x++) drive(x, 0, 1'b1, 0, 1, 1'b0);
    drive(200, 0, 1'b1, 0, 0, 1'b1);
    drive(201, 0, 1'b1, 0, 1, 1'b0);
    check_zero("midline_reset");
    for (int x = 202; x < 206; x++) drive(x, 0, 1'b1, (x == 205), 1, 1'b0);
    drive(0, 0, 1'b0, 0, 1, 1'b0);
    for (int x = 190; x < 194; x++) drive(x, 1, 1'b1, (x == 190), 1, 1'b0);
    drive(0, 1, 1'b0, 0, 1, 1'b0);
    for (int x = 190; x < 222; x++) drive(x, 0, 1'b1, (x == 190 || x == 221), 1, 1'b0);
    drive(0, 0, 1'b0, 0, 1, 1'b0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1'b0, 0, 1, 1'b0);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
